// File: rtl/fft_sdf_ctrl.sv
// Sequencer for a 32-point radix-2 DIF SDF FFT: stage selects, twiddle indices, advance and flush.
// Optional output frame counter when FFT_CTRL_FRMCNT_EN is defined.
module fft_sdf_ctrl #(
    parameter int unsigned STAGE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        sort_ready,
    output logic        pipe_en,
    output logic [4:0]  bf_en,
    output logic [19:0] tw_addr,
    output logic        out_valid,
    output logic        start_sorting,
    output logic        err_ovf
`ifdef FFT_CTRL_FRMCNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned FRAME_LAT = 31 + 5 * STAGE_LAT;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_t;

    function automatic logic [4:0] stage_off(input int unsigned k);
        int unsigned s;
        s = 0;
        for (int unsigned j = 0; j < k; j++) s += (32'd16 >> j) + STAGE_LAT;
        return 5'(s);
    endfunction

    state_t                 state_q, state_d;
    logic [4:0]             gcnt_q;
    logic [4:0]             ocnt_q;
    logic [FRAME_LAT-1:0]   vsr_q;
    logic                   err_q;
    logic                   flush_now;
    logic                   drain_empty;
    logic                   adv;
    logic                   head;

    // A frame boundary with no new input starts draining in the same cycle, keeping latency fixed.
    assign flush_now   = (state_q == StFlush) ||
                         ((state_q == StRun) && (gcnt_q == '0) && (vsr_q != '0));
    assign drain_empty = (vsr_q[FRAME_LAT-2:0] == '0);
    assign adv         = !rst && (in_valid || flush_now);
    assign head        = out_valid && (ocnt_q == '0);

    assign pipe_en       = adv;
    assign out_valid     = vsr_q[FRAME_LAT-1] && adv;
    assign start_sorting = head && sort_ready;
    assign err_ovf       = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun: begin
                if (!in_valid) begin
                    if (vsr_q == '0)        state_d = StIdle;
                    else if (gcnt_q == '0)  state_d = drain_empty ? StIdle : StFlush;
                end
            end
            StFlush: begin
                if (in_valid)         state_d = StRun;
                else if (drain_empty) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gcnt_q  <= '0;
            ocnt_q  <= '0;
            vsr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (adv) begin
                gcnt_q <= gcnt_q + 5'd1;
                vsr_q  <= {vsr_q[FRAME_LAT-2:0], in_valid};
            end
            if (out_valid) ocnt_q <= ocnt_q + 5'd1;
            if (head && !sort_ready) err_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam logic [4:0] Off = stage_off(k);
        logic [4:0] lc;
        assign lc                = gcnt_q - Off;
        assign bf_en[k]          = !rst && lc[4-k];
        // Index is {lc[3-k:0], k zeros}; zero while the stage is in butterfly mode.
        assign tw_addr[4*k +: 4] = (rst || lc[4-k]) ? 4'd0 : 4'(lc << k);
    end

`ifdef FFT_CTRL_FRMCNT_EN
    logic [15:0] frame_cnt_q;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (out_valid && (ocnt_q == 5'd31)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Scoreboard bench for fft_sdf_ctrl: expected output events queued by stimulus, popped by a monitor.
module tb_fft_sdf_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        sort_ready = 1'b1;
    logic        pipe_en;
    logic [4:0]  bf_en;
    logic [19:0] tw_addr;
    logic        out_valid;
    logic        start_sorting;
    logic        err_ovf;
`ifdef FFT_CTRL_FRMCNT_EN
    logic [15:0] frame_cnt;
`endif

    fft_sdf_ctrl #(.STAGE_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .sort_ready   (sort_ready),
        .pipe_en      (pipe_en),
        .bf_en        (bf_en),
        .tw_addr      (tw_addr),
        .out_valid    (out_valid),
        .start_sorting(start_sorting),
        .err_ovf      (err_ovf)
`ifdef FFT_CTRL_FRMCNT_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   at;
        logic ss;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Queue the expected output samples: cycles first..first+n-1, a sort pulse at each frame head.
    task automatic expect_outs(input int first, input int n, input logic first_ok);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e.at = first + i;
            e.ss = ((i % 32) == 0) && ((i != 0) || first_ok);
            exp_q.push_back(e);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pipe_en"},   32'(pipe_en),       32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid),     32'd0);
        chk({tag, "_start"},     32'(start_sorting), 32'd0);
        chk({tag, "_err_ovf"},   32'(err_ovf),       32'd0);
        chk({tag, "_bf_en"},     32'(bf_en),         32'd0);
        chk({tag, "_tw_addr"},   32'(tw_addr),       32'd0);
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        in_valid   = 1'b0;
        sort_ready = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk_all_zero("reset");
`ifdef FFT_CTRL_FRMCNT_EN
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic cyc_begin(input logic iv, input logic sr);
        in_valid   = iv;
        sort_ready = sr;
        @(negedge clk);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: every presented output sample must match the head of the expectation queue.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid cycle=%0d got=1 expected=0", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("out_cycle", 32'(cyc), 32'(e.at));
                chk("start_sorting", 32'(start_sorting), 32'(e.ss));
            end
        end else if (!rst && start_sorting) begin
            checks++;
            errors++;
            $display("FAIL stray_start_sorting cycle=%0d got=1 expected=0", cyc);
        end
    end

    initial begin
        // Single frame then flush.
        reset_dut();
        expect_outs(36, 32, 1'b1);
        for (int n = 0; n < 72; n++) begin
            cyc_begin(n < 32, 1'b1);
            if (n == 0) begin
                chk("s1_bf_en_g0", 32'(bf_en), 32'b00110);
                chk("s1_tw_g0", 32'(tw_addr), 32'h08000);
            end
            if (n == 31 || n == 32 || n == 67) chk("s1_pipe_en_hi", 32'(pipe_en), 32'd1);
            if (n == 68 || n == 70) chk("s1_pipe_en_idle", 32'(pipe_en), 32'd0);
            cyc_end();
        end
        chk("s1_pending", 32'(exp_q.size()), 32'd0);

        // Three back-to-back frames.
        reset_dut();
        expect_outs(36, 96, 1'b1);
        for (int n = 0; n < 136; n++) begin
            int g;
            g = n % 32;
            cyc_begin(n < 96, 1'b1);
            if (n < 96) begin
                chk("s2_bf0", 32'(bf_en[0]), 32'(g >= 16));
                if (g < 16) chk("s2_tw0", 32'(tw_addr[3:0]), 32'(g));
            end
            if (n == 5) begin
                chk("s2_bf_en_g5", 32'(bf_en), 32'b11000);
                chk("s2_tw_g5", 32'(tw_addr), 32'h00C85);
            end
            if (n == 20) begin
                chk("s2_bf_en_g20", 32'(bf_en), 32'b00001);
                chk("s2_tw_g20", 32'(tw_addr), 32'h08860);
            end
            cyc_end();
        end
        chk("s2_pending", 32'(exp_q.size()), 32'd0);
`ifdef FFT_CTRL_FRMCNT_EN
        chk("s6_frame_cnt", 32'(frame_cnt), 32'd3);
`endif

        // Mid-frame input gap stalls the whole pipe.
        reset_dut();
        expect_outs(41, 32, 1'b1);
        for (int n = 0; n < 77; n++) begin
            cyc_begin((n < 10) || (n >= 15 && n < 37), 1'b1);
            if (n >= 10 && n <= 14) chk("s3_pipe_en_gap", 32'(pipe_en), 32'd0);
            if (n == 9 || n == 15 || n == 37) chk("s3_pipe_en_hi", 32'(pipe_en), 32'd1);
            cyc_end();
        end
        chk("s3_pending", 32'(exp_q.size()), 32'd0);

        // Sorter not ready at the frame head.
        reset_dut();
        expect_outs(36, 32, 1'b0);
        for (int n = 0; n < 72; n++) begin
            cyc_begin(n < 32, n != 36);
            if (n == 36) chk("s4_err_before", 32'(err_ovf), 32'd0);
            if (n == 37 || n == 71) chk("s4_err_sticky", 32'(err_ovf), 32'd1);
            cyc_end();
        end
        chk("s4_pending", 32'(exp_q.size()), 32'd0);

        // Reset pulse mid-frame, then a fresh frame.
        reset_dut();
        expect_outs(36, 14, 1'b1);
        for (int n = 0; n < 127; n++) begin
            if (n == 50) begin
                rst = 1'b1;
                #1;
                chk_all_zero("s5_async");
                #1;
                rst = 1'b0;
                chk("s5_pending_at_rst", 32'(exp_q.size()), 32'd0);
                expect_outs(91, 32, 1'b1);
            end
            cyc_begin((n < 32) || (n >= 55 && n < 87), 1'b1);
            cyc_end();
        end
        chk("s5_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
